// File: rtl/oam_dma_arbiter.sv
// CPU bus owner shared between the 6502 core and the sprite (OAM) DMA engine.
// A write to DMA_REG_ADDR stalls the core and copies XFER_LEN bytes from {page,idx} to OAM_DATA_ADDR.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        cpuClk,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDataWr,
  input  logic        cpuWrEn,
  output logic [7:0]  cpuDataRd,
  output logic        cpuHalt,
  output logic [15:0] busAddr,
  output logic [7:0]  busDataWr,
  output logic        busWrEn,
  input  logic [7:0]  busDataRd,
  output logic        dmaActive
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t     state, state_next;
  logic [7:0] page, page_next;
  logic [7:0] idx, idx_next;
  logic [7:0] data_buf, data_buf_next;
  logic       cycle_odd;

  // State register; cycle_odd tracks CPU cycle parity so READ always lands on an even cycle
  always_ff @(posedge cpuClk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      page      <= 8'h00;
      idx       <= 8'h00;
      data_buf  <= 8'h00;
      cycle_odd <= 1'b0;
    end else begin
      state     <= state_next;
      page      <= page_next;
      idx       <= idx_next;
      data_buf  <= data_buf_next;
      cycle_odd <= ~cycle_odd;
    end
  end

  // Next-state and bus steering; bus passes the core through unless a transfer owns it
  always_comb begin
    state_next    = state;
    page_next     = page;
    idx_next      = idx;
    data_buf_next = data_buf;
    busAddr       = cpuAddr;
    busDataWr     = cpuDataWr;
    busWrEn       = cpuWrEn;
    case (state)
      IDLE: begin
        if (cpuWrEn && (cpuAddr == DMA_REG_ADDR)) begin
          page_next  = cpuDataWr;
          idx_next   = 8'h00;
          state_next = HALT;
        end
      end
      HALT: begin
        busWrEn    = 1'b0;
        state_next = cycle_odd ? READ : ALIGN;
      end
      ALIGN: begin
        busWrEn    = 1'b0;
        state_next = READ;
      end
      READ: begin
        busAddr       = {page, idx};
        busWrEn       = 1'b0;
        data_buf_next = busDataRd;
        state_next    = WRITE;
      end
      WRITE: begin
        busAddr    = OAM_DATA_ADDR;
        busDataWr  = data_buf;
        busWrEn    = 1'b1;
        idx_next   = idx + 8'd1;
        state_next = (idx == LAST_IDX) ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpuDataRd = busDataRd;
  assign cpuHalt   = (state != IDLE);
  assign dmaActive = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: a ROM model feeds the bus, expected OAM bytes are queued per trigger.
module tb_oam_dma_arbiter;

  logic        cpuClk;
  logic        reset;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDataWr;
  logic        cpuWrEn;
  logic [7:0]  cpuDataRd;
  logic        cpuHalt;
  logic [15:0] busAddr;
  logic [7:0]  busDataWr;
  logic        busWrEn;
  logic [7:0]  busDataRd;
  logic        dmaActive;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    bit          first;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [0:65535];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pairs = 0;
  logic        tb_odd;
  logic [15:0] prev_addr;
  logic        prev_odd;

  oam_dma_arbiter dut (
    .cpuClk    (cpuClk),
    .reset     (reset),
    .cpuAddr   (cpuAddr),
    .cpuDataWr (cpuDataWr),
    .cpuWrEn   (cpuWrEn),
    .cpuDataRd (cpuDataRd),
    .cpuHalt   (cpuHalt),
    .busAddr   (busAddr),
    .busDataWr (busDataWr),
    .busWrEn   (busWrEn),
    .busDataRd (busDataRd),
    .dmaActive (dmaActive)
  );

  initial cpuClk = 1'b0;
  always #5 cpuClk = ~cpuClk;

  assign busDataRd = mem[busAddr];

  // Cycle parity as defined for the core: first cycle after reset release is even
  always @(posedge cpuClk or posedge reset) begin
    if (reset) tb_odd <= 1'b0;
    else       tb_odd <= ~tb_odd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // OAM write monitor: each write to $2004 pops one expected byte; the preceding cycle was its READ
  always @(negedge cpuClk) begin
    if (!reset) begin
      if (busWrEn && busAddr == 16'h2004) begin
        if (sb.size() == 0) begin
          check("oam_unexpected_write", 32'(busDataWr), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("oam_data", 32'(busDataWr), 32'(e.data));
          check("read_addr", 32'(prev_addr), 32'(e.addr));
          if (e.first) check("first_read_even", 32'(prev_odd), 32'd0);
        end
        pairs++;
      end
      prev_addr = busAddr;
      prev_odd  = tb_odd;
    end
  end

  task automatic idle_cycle();
    cpuAddr   = 16'h0000;
    cpuDataWr = 8'h00;
    cpuWrEn   = 1'b0;
    @(posedge cpuClk); #1;
  endtask

  task automatic push_exp(input logic [7:0] pg);
    for (int i = 0; i < 256; i++) begin
      exp_t e;
      e.addr  = {pg, 8'(i)};
      e.data  = mem[{pg, 8'(i)}];
      e.first = (i == 0);
      sb.push_back(e);
    end
  endtask

  // Triggers a transfer (optionally on a chosen parity) and measures the stall from the trigger cycle
  task automatic run_dma(input logic [7:0] pg, input int parity);
    int stall;
    int exp_len;
    if (parity >= 0) begin
      while (int'(tb_odd) != parity) idle_cycle();
    end
    exp_len = tb_odd ? 515 : 514;
    push_exp(pg);
    cpuAddr   = 16'h4014;
    cpuDataWr = pg;
    cpuWrEn   = 1'b1;
    #1;
    check("trigger_pass_wren", 32'(busWrEn), 32'd1);
    check("trigger_pass_addr", 32'(busAddr), 32'h4014);
    check("trigger_not_halted", 32'(cpuHalt), 32'd0);
    @(posedge cpuClk); #1;
    cpuAddr   = 16'h8000;
    cpuDataWr = 8'h00;
    cpuWrEn   = 1'b0;
    stall = 1;
    while (cpuHalt && stall < 600) begin
      stall++;
      @(posedge cpuClk); #1;
    end
    check("stall_len", 32'(stall), 32'(exp_len));
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("dma_inactive_after", 32'(dmaActive), 32'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
    for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i) ^ 8'hA5;

    reset     = 1'b1;
    cpuAddr   = 16'hABCD;
    cpuDataWr = 8'h3C;
    cpuWrEn   = 1'b1;
    #2;
    check("reset_halt", 32'(cpuHalt), 32'd0);
    check("reset_active", 32'(dmaActive), 32'd0);
    check("reset_pass_addr", 32'(busAddr), 32'hABCD);
    check("reset_pass_data", 32'(busDataWr), 32'h3C);
    check("reset_pass_wren", 32'(busWrEn), 32'd1);
    #10 reset = 1'b0;
    @(posedge cpuClk); #1;

    // Idle passthrough: read then write
    cpuAddr = 16'h0123; cpuDataWr = 8'h00; cpuWrEn = 1'b0; #1;
    check("idle_rd_addr", 32'(busAddr), 32'h0123);
    check("idle_rd_wren", 32'(busWrEn), 32'd0);
    check("idle_rd_data", 32'(cpuDataRd), 32'(mem[16'h0123]));
    check("idle_rd_halt", 32'(cpuHalt), 32'd0);
    @(posedge cpuClk); #1;
    cpuAddr = 16'h0300; cpuDataWr = 8'h07; cpuWrEn = 1'b1; #1;
    check("idle_wr_addr", 32'(busAddr), 32'h0300);
    check("idle_wr_data", 32'(busDataWr), 32'h07);
    check("idle_wr_wren", 32'(busWrEn), 32'd1);
    check("idle_wr_halt", 32'(cpuHalt), 32'd0);
    @(posedge cpuClk); #1;

    run_dma(8'h02, 1);   // odd trigger cycle: HALT lands even, so ALIGN is inserted
    idle_cycle();
    run_dma(8'h02, 0);   // even trigger cycle: no ALIGN
    idle_cycle();
    run_dma(8'hFF, -1);  // top page, last read must be $FFFF
    run_dma(8'h05, -1);  // back-to-back on the first unhalted cycle

    // Reset mid-transfer at pair 100
    push_exp(8'h03);
    cpuAddr = 16'h4014; cpuDataWr = 8'h03; cpuWrEn = 1'b1;
    w = pairs;
    @(posedge cpuClk); #1;
    cpuAddr = 16'h1234; cpuDataWr = 8'h5A; cpuWrEn = 1'b0;
    for (int t = 0; t < 1000 && pairs < w + 100; t++) begin
      @(posedge cpuClk); #1;
    end
    check("mid_reset_reached_100", 32'(pairs - w), 32'd100);
    check("mid_halt_before_reset", 32'(cpuHalt), 32'd1);
    reset = 1'b1; #1;
    check("mid_reset_halt", 32'(cpuHalt), 32'd0);
    check("mid_reset_active", 32'(dmaActive), 32'd0);
    check("mid_reset_pass_addr", 32'(busAddr), 32'h1234);
    check("mid_reset_pass_wren", 32'(busWrEn), 32'd0);
    sb.delete();
    @(negedge cpuClk); #1;
    reset = 1'b0;
    @(posedge cpuClk); #1;
    check("post_reset_idle", 32'(cpuHalt), 32'd0);
    run_dma(8'h04, -1);

    repeat (3) idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
